// File: rtl/restoring_divider.sv
// restoring_divider: sequential 8-bit / 4-bit restoring divider.
//   One restoring iteration per clock (8 iterations), then a fix-up cycle
//   that publishes the result. A zero divisor skips the iterations entirely.
//   Optional signed support is compiled in with RESTORING_DIVIDER_SIGNED_EN;
//   without it the sgn port is ignored and ovf is tied low.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request, sampled only while idle
//   sgn        in   1 = two's-complement operands (signed build only)
//   dividend   in   [7:0] numerator, latched with start
//   divisor    in   [3:0] denominator, latched with start
//   quotient   out  [7:0] registered result, held until the next result
//   remainder  out  [3:0] registered result, held until the next result
//   busy       out  high while an operation is in progress
//   done       out  one-cycle pulse when the results update
//   dz         out  divide-by-zero flag, valid with done, held
//   ovf        out  signed overflow flag (-128 / -1), valid with done, held
module restoring_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sgn,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       dz,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t     state_r, state_nx_s;
    logic [2:0] cnt_r, cnt_nx_s;
    logic [7:0] quo_r, quo_nx_s;          // working quotient / shifting dividend
    logic [3:0] rem_r, rem_nx_s;          // partial remainder
    logic [3:0] dvs_r, dvs_nx_s;          // divisor magnitude
    logic [7:0] quotient_r, quotient_nx_s;
    logic [3:0] remainder_r, remainder_nx_s;
    logic       busy_r, busy_nx_s;
    logic       done_r, done_nx_s;
    logic       dz_r, dz_nx_s;
    logic [4:0] shift_s;
    logic [5:0] trial_s;

`ifdef RESTORING_DIVIDER_SIGNED_EN
    logic neg_q_r, neg_q_nx_s;            // quotient must be negated at fix-up
    logic neg_r_r, neg_r_nx_s;            // remainder takes the dividend's sign
    logic ovf_case_r, ovf_case_nx_s;      // operands were -128 / -1
    logic ovf_r, ovf_nx_s;

    function automatic logic [7:0] mag8(input logic [7:0] v, input logic en);
        return (en && v[7]) ? (8'd0 - v) : v;
    endfunction

    function automatic logic [3:0] mag4(input logic [3:0] v, input logic en);
        return (en && v[3]) ? (4'd0 - v) : v;
    endfunction
`else
    logic sgn_unused_s;
    assign sgn_unused_s = sgn;
`endif

    // Next-state, datapath and result computation for the divider FSM
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        quo_nx_s       = quo_r;
        rem_nx_s       = rem_r;
        dvs_nx_s       = dvs_r;
        quotient_nx_s  = quotient_r;
        remainder_nx_s = remainder_r;
        busy_nx_s      = busy_r;
        done_nx_s      = 1'b0;
        dz_nx_s        = dz_r;
`ifdef RESTORING_DIVIDER_SIGNED_EN
        neg_q_nx_s     = neg_q_r;
        neg_r_nx_s     = neg_r_r;
        ovf_case_nx_s  = ovf_case_r;
        ovf_nx_s       = ovf_r;
`endif
        // Shifted partial remainder is at most 29, so a 6-bit difference
        // carries a clean sign bit for the trial subtraction.
        shift_s = {rem_r, quo_r[7]};
        trial_s = {1'b0, shift_s} - {2'b00, dvs_r};

        case (state_r)
            IDLE: begin
                if (start) begin
                    cnt_nx_s  = 3'd0;
                    busy_nx_s = 1'b1;
                    rem_nx_s  = 4'd0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
                    quo_nx_s      = mag8(dividend, sgn);
                    dvs_nx_s      = mag4(divisor, sgn);
                    neg_q_nx_s    = sgn & (dividend[7] ^ divisor[3]);
                    neg_r_nx_s    = sgn & dividend[7];
                    ovf_case_nx_s = sgn & (dividend == 8'h80) & (divisor == 4'hF);
`else
                    quo_nx_s = dividend;
                    dvs_nx_s = divisor;
`endif
                    if (divisor == 4'd0) begin
                        state_nx_s = FIX;
                    end else begin
                        state_nx_s = CALC;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                // A restore only happens when shift_s < divisor <= 15, and a
                // kept difference is below the divisor, so 4 bits suffice.
                if (trial_s[5]) begin
                    rem_nx_s = shift_s[3:0];
                    quo_nx_s = {quo_r[6:0], 1'b0};
                end else begin
                    rem_nx_s = trial_s[3:0];
                    quo_nx_s = {quo_r[6:0], 1'b1};
                end
                cnt_nx_s = cnt_r + 3'd1;
                if (cnt_r == 3'd7) begin
                    state_nx_s = FIX;
                end else begin
                    state_nx_s = CALC;
                end
            end
            FIX: begin
                if (dvs_r == 4'd0) begin
                    quotient_nx_s  = 8'hFF;
                    remainder_nx_s = 4'h0;
                    dz_nx_s        = 1'b1;
`ifdef RESTORING_DIVIDER_SIGNED_EN
                    ovf_nx_s       = 1'b0;
`endif
                end else begin
                    dz_nx_s = 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
                    if (ovf_case_r) begin
                        quotient_nx_s  = 8'h80;
                        remainder_nx_s = 4'h0;
                        ovf_nx_s       = 1'b1;
                    end else begin
                        quotient_nx_s  = neg_q_r ? (8'd0 - quo_r) : quo_r;
                        remainder_nx_s = neg_r_r ? (4'd0 - rem_r) : rem_r;
                        ovf_nx_s       = 1'b0;
                    end
`else
                    quotient_nx_s  = quo_r;
                    remainder_nx_s = rem_r;
`endif
                end
                done_nx_s  = 1'b1;
                busy_nx_s  = 1'b0;
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            quo_r       <= 8'd0;
            rem_r       <= 4'd0;
            dvs_r       <= 4'd0;
            quotient_r  <= 8'h00;
            remainder_r <= 4'h0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dz_r        <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            ovf_case_r  <= 1'b0;
            ovf_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            quo_r       <= quo_nx_s;
            rem_r       <= rem_nx_s;
            dvs_r       <= dvs_nx_s;
            quotient_r  <= quotient_nx_s;
            remainder_r <= remainder_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
            dz_r        <= dz_nx_s;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            neg_q_r     <= neg_q_nx_s;
            neg_r_r     <= neg_r_nx_s;
            ovf_case_r  <= ovf_case_nx_s;
            ovf_r       <= ovf_nx_s;
`endif
        end
    end

    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign dz        = dz_r;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    assign ovf       = ovf_r;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: self-checking bench for restoring_divider.
//   Directed scenarios plus randomized operations, each compared against an
//   arithmetic reference model (integer / and %).
`timescale 1ns/1ps
module tb_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sgn;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dz;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    logic [7:0] held_q = 8'h00;
    logic [3:0] held_r = 4'h0;

    restoring_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sgn       (sgn),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dz        (dz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer division (truncating toward zero, so the
    // remainder carries the dividend's sign).
    function automatic void model(input logic s, input logic [7:0] a, input logic [3:0] b,
                                  output logic [7:0] q, output logic [3:0] r,
                                  output logic z, output logic o);
        int ai, bi, qi, ri;
        logic sg;
`ifdef RESTORING_DIVIDER_SIGNED_EN
        sg = s;
`else
        sg = s & 1'b0;
`endif
        q = 8'h00; r = 4'h0; z = 1'b0; o = 1'b0;
        if (b == 4'd0) begin
            q = 8'hFF; r = 4'h0; z = 1'b1;
        end else begin
            ai = sg ? int'($signed(a)) : int'(a);
            bi = sg ? int'($signed(b)) : int'(b);
            if (sg && ai == -128 && bi == -1) begin
                q = 8'h80; r = 4'h0; o = 1'b1;
            end else begin
                qi = ai / bi;
                ri = ai % bi;
                q = qi[7:0];
                r = ri[3:0];
            end
        end
    endfunction

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Issue one operation from a negedge; returns at the negedge where done
    // is seen. When lat == inj a stray 50/5 start is driven while busy.
    task automatic run_op(input logic s, input logic [7:0] a, input logic [3:0] b, input int inj);
        logic [7:0] eq;
        logic [3:0] er;
        logic ez, eo;
        int lat;
        model(s, a, b, eq, er, ez, eo);
        sgn = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (done) break;
            if (lat == inj) begin
                start = 1'b1; dividend = 8'd50; divisor = 4'd5;
            end else begin
                start = 1'b0;
            end
            chk("busy_during_op", busy, 1'b1);
            chk("quotient_held", quotient, held_q);
            @(posedge clk);
            lat++;
        end
        start = 1'b0;
        chk("done_seen", done, 1'b1);
        chk("latency", lat, ez ? 1 : 9);
        chk("busy_after_done", busy, 1'b0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("dz", dz, ez);
        chk("ovf", ovf, eo);
        held_q = eq;
        held_r = er;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; dividend = 8'd0; divisor = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, 8'h00);
        chk("rst_remainder", remainder, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dz", dz, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Unsigned 100/7
        run_op(1'b0, 8'd100, 4'd7, -1);
        chk("u100_7_q", quotient, 8'd14);
        chk("u100_7_r", remainder, 4'd2);
        idle(2);

        // Signed -100/7 and -128/-1
        run_op(1'b1, 8'h9C, 4'd7, -1);
`ifdef RESTORING_DIVIDER_SIGNED_EN
        chk("s_m100_7_q", quotient, 8'hF2);
        chk("s_m100_7_r", remainder, 4'hE);
`endif
        idle(1);
        run_op(1'b1, 8'h80, 4'hF, -1);
`ifdef RESTORING_DIVIDER_SIGNED_EN
        chk("s_ovf_flag", ovf, 1'b1);
        chk("s_ovf_q", quotient, 8'h80);
`endif
        idle(1);
        run_op(1'b0, 8'd255, 4'd15, -1);
        chk("u255_15_q", quotient, 8'd17);

        // Divide by zero, then 9/3 back-to-back in the done cycle
        idle(1);
        run_op(1'b0, 8'd77, 4'd0, -1);
        chk("dz_flag", dz, 1'b1);
        run_op(1'b0, 8'd9, 4'd3, -1);
        chk("after_dz_q", quotient, 8'd3);

        // Stray start during 100/7 ignored, then 50/5 started in done cycle
        idle(2);
        run_op(1'b0, 8'd100, 4'd7, 4);
        chk("ignored_start_q", quotient, 8'd14);
        run_op(1'b0, 8'd50, 4'd5, -1);
        chk("chained_q", quotient, 8'd10);

        // Reset mid-operation after a divide-by-zero left dz and quotient set
        idle(1);
        run_op(1'b0, 8'd10, 4'd0, -1);
        sgn = 1'b0; dividend = 8'd100; divisor = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_quotient", quotient, 8'h00);
        chk("mid_rst_remainder", remainder, 4'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_dz", dz, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_ovf", ovf, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_done", done, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", done, 1'b0);
        end
        held_q = 8'h00;
        held_r = 4'h0;
        run_op(1'b0, 8'd100, 4'd7, -1);

        // Randomized operations against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [7:0] ra;
            logic [3:0] rb;
            logic rs;
            ra = 8'($urandom);
            rb = 4'($urandom);
            rs = 1'($urandom);
            if (k % 8 == 0) ra = 8'h80;
            run_op(rs, ra, rb, -1);
            if ($urandom_range(1, 0) == 1) idle(1);
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
